// File: rtl/sevenseg_scan_decoder.sv
// Recovers hex nibbles from a multiplexed active-low seven-segment bus with glitch filtering.
// Optional SEG_STALE_TIMEOUT_EN: drops digit_valid/digit_blank on digits not refreshed within TIMEOUT_CYCLES.
module sevenseg_scan_decoder #(
  parameter int unsigned NUM_DIGITS     = 4,
  parameter int unsigned STABLE_CYCLES  = 4,
  parameter int unsigned TIMEOUT_CYCLES = 1000000
) (
  input  logic                                                   clk,
  input  logic                                                   rst,
  input  logic [6:0]                                             seg,
  input  logic [NUM_DIGITS-1:0]                                  an,
  output logic [4*NUM_DIGITS-1:0]                                digits,
  output logic [NUM_DIGITS-1:0]                                  digit_valid,
  output logic [NUM_DIGITS-1:0]                                  digit_blank,
  output logic [NUM_DIGITS-1:0]                                  digit_err,
  output logic                                                   upd,
  output logic [((NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1)-1:0] upd_idx
);

  localparam int unsigned SAMP_W = NUM_DIGITS + 7;
  localparam int unsigned IDX_W  = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int unsigned CNT_W  = $clog2(STABLE_CYCLES + 1);

  if (NUM_DIGITS < 1 || NUM_DIGITS > 8 || STABLE_CYCLES < 1 || TIMEOUT_CYCLES < 1) begin : g_bad_params
    $error("sevenseg_scan_decoder: illegal parameter value");
  end

  logic [SAMP_W-1:0]       samp_q, samp_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic [4*NUM_DIGITS-1:0] digits_q, digits_d;
  logic [NUM_DIGITS-1:0]   valid_q, valid_d;
  logic [NUM_DIGITS-1:0]   blank_q, blank_d;
  logic [NUM_DIGITS-1:0]   err_q, err_d;
  logic                    upd_q, upd_d;
  logic [IDX_W-1:0]        upd_idx_q, upd_idx_d;

  logic [NUM_DIGITS-1:0]   an_s;
  logic [6:0]              seg_s;
  logic [4:0]              dec_c;
  logic [IDX_W-1:0]        k_c;
  int unsigned             zeros_c;
  logic                    stable_c;
  logic                    commit_c;

`ifdef SEG_STALE_TIMEOUT_EN
  localparam int unsigned TO_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [NUM_DIGITS-1:0][TO_W-1:0] to_q, to_d;
`endif

  // {hit, nibble} for the sixteen legal glyphs
  function automatic logic [4:0] seg_decode(input logic [6:0] s);
    logic [4:0] r;
    case (s)
      7'h40:   r = 5'h10;
      7'h79:   r = 5'h11;
      7'h24:   r = 5'h12;
      7'h30:   r = 5'h13;
      7'h19:   r = 5'h14;
      7'h12:   r = 5'h15;
      7'h02:   r = 5'h16;
      7'h78:   r = 5'h17;
      7'h00:   r = 5'h18;
      7'h10:   r = 5'h19;
      7'h08:   r = 5'h1A;
      7'h03:   r = 5'h1B;
      7'h46:   r = 5'h1C;
      7'h21:   r = 5'h1D;
      7'h06:   r = 5'h1E;
      7'h0E:   r = 5'h1F;
      default: r = 5'h00;
    endcase
    return r;
  endfunction

  // Stability filter: the incoming bus is compared against the last registered sample
  always_comb begin
    samp_d   = {an, seg};
    an_s     = samp_q[SAMP_W-1:7];
    seg_s    = samp_q[6:0];
    dec_c    = seg_decode(seg_s);
    zeros_c  = 0;
    k_c      = '0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (!an_s[i]) begin
        zeros_c = zeros_c + 1;
        k_c     = IDX_W'(i);
      end
    end
    stable_c = (samp_d == samp_q);
    if (!stable_c) begin
      cnt_d = '0;
    end else if (cnt_q != CNT_W'(STABLE_CYCLES)) begin
      cnt_d = cnt_q + CNT_W'(1);
    end else begin
      cnt_d = cnt_q;
    end
    commit_c = stable_c && (cnt_q == CNT_W'(STABLE_CYCLES - 1)) && (zeros_c == 1);
  end

  // Per-digit output update on commit (and stale timeout when enabled)
  always_comb begin
    digits_d  = digits_q;
    valid_d   = valid_q;
    blank_d   = blank_q;
    err_d     = err_q;
    upd_d     = commit_c;
    upd_idx_d = commit_c ? k_c : upd_idx_q;
`ifdef SEG_STALE_TIMEOUT_EN
    to_d      = to_q;
`endif
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (commit_c && (k_c == IDX_W'(i))) begin
        if (dec_c[4]) begin
          digits_d[4*i +: 4] = dec_c[3:0];
          valid_d[i]         = 1'b1;
          blank_d[i]         = 1'b0;
          err_d[i]           = 1'b0;
        end else if (seg_s == 7'h7F) begin
          digits_d[4*i +: 4] = 4'h0;
          valid_d[i]         = 1'b1;
          blank_d[i]         = 1'b1;
          err_d[i]           = 1'b0;
        end else begin
          err_d[i]           = 1'b1;
        end
`ifdef SEG_STALE_TIMEOUT_EN
        to_d[i] = '0;
      end else begin
        if (to_q[i] == TO_W'(TIMEOUT_CYCLES - 1)) begin
          valid_d[i] = 1'b0;
          blank_d[i] = 1'b0;
        end
        if (to_q[i] != TO_W'(TIMEOUT_CYCLES)) begin
          to_d[i] = to_q[i] + TO_W'(1);
        end
`endif
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      samp_q    <= '1;
      cnt_q     <= '0;
      digits_q  <= '0;
      valid_q   <= '0;
      blank_q   <= '0;
      err_q     <= '0;
      upd_q     <= 1'b0;
      upd_idx_q <= '0;
`ifdef SEG_STALE_TIMEOUT_EN
      to_q      <= '0;
`endif
    end else begin
      samp_q    <= samp_d;
      cnt_q     <= cnt_d;
      digits_q  <= digits_d;
      valid_q   <= valid_d;
      blank_q   <= blank_d;
      err_q     <= err_d;
      upd_q     <= upd_d;
      upd_idx_q <= upd_idx_d;
`ifdef SEG_STALE_TIMEOUT_EN
      to_q      <= to_d;
`endif
    end
  end

  assign digits      = digits_q;
  assign digit_valid = valid_q;
  assign digit_blank = blank_q;
  assign digit_err   = err_q;
  assign upd         = upd_q;
  assign upd_idx     = upd_idx_q;

endmodule

// File: tb/tb_sevenseg_scan_decoder.sv
// Directed bench for sevenseg_scan_decoder: reset, decode latency, glitch/error/anode handling, sweep, timeout.
module tb_sevenseg_scan_decoder;

  logic        clk = 1'b0;
  logic        rst;
  logic [6:0]  seg;
  logic [3:0]  an;
  logic [15:0] digits;
  logic [3:0]  digit_valid;
  logic [3:0]  digit_blank;
  logic [3:0]  digit_err;
  logic        upd;
  logic [1:0]  upd_idx;

  int total = 0;
  int bad   = 0;

  sevenseg_scan_decoder #(
    .NUM_DIGITS(4),
    .STABLE_CYCLES(4),
    .TIMEOUT_CYCLES(50)
  ) dut (
    .clk(clk),
    .rst(rst),
    .seg(seg),
    .an(an),
    .digits(digits),
    .digit_valid(digit_valid),
    .digit_blank(digit_blank),
    .digit_err(digit_err),
    .upd(upd),
    .upd_idx(upd_idx)
  );

  always #5 clk = ~clk;

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; an = 4'b1110; seg = 7'h12;
    for (int c = 0; c < 2; c++) begin
      tick(1);
      total++; if (upd !== 1'b0) begin bad++; $display("FAIL reset_upd got=%b exp=0", upd); end
    end
    total++; if (digits !== 16'h0000) begin bad++; $display("FAIL reset_digits got=%h exp=0000", digits); end
    total++; if (digit_valid !== 4'b0000) begin bad++; $display("FAIL reset_valid got=%b exp=0000", digit_valid); end
    total++; if (digit_blank !== 4'b0000) begin bad++; $display("FAIL reset_blank got=%b exp=0000", digit_blank); end
    total++; if (digit_err !== 4'b0000) begin bad++; $display("FAIL reset_err got=%b exp=0000", digit_err); end
    total++; if (upd_idx !== 2'd0) begin bad++; $display("FAIL reset_upd_idx got=%0d exp=0", upd_idx); end
    rst = 1'b0;
  endtask

  task automatic test_basic_decode();
    int pulses = 0;
    tick(4);
    total++; if (upd !== 1'b0) begin bad++; $display("FAIL basic_early_upd got=%b exp=0", upd); end
    tick(1);
    total++; if (upd !== 1'b1) begin bad++; $display("FAIL basic_upd got=%b exp=1", upd); end
    total++; if (upd_idx !== 2'd0) begin bad++; $display("FAIL basic_upd_idx got=%0d exp=0", upd_idx); end
    total++; if (digits[3:0] !== 4'h5) begin bad++; $display("FAIL basic_digit got=%h exp=5", digits[3:0]); end
    total++; if (digit_valid !== 4'b0001) begin bad++; $display("FAIL basic_valid got=%b exp=0001", digit_valid); end
    for (int c = 0; c < 20; c++) begin
      tick(1);
      if (upd === 1'b1) pulses++;
    end
    total++; if (pulses !== 0) begin bad++; $display("FAIL basic_hold_recommit got=%0d exp=0", pulses); end
  endtask

  task automatic test_glitch_reject();
    int pulses = 0;
    int saw3   = 0;
    an = 4'b1011; seg = 7'h30;
    for (int c = 0; c < 3; c++) begin
      tick(1);
      if (upd === 1'b1) pulses++;
      if (digits[11:8] === 4'h3) saw3++;
    end
    seg = 7'h24;
    for (int c = 0; c < 10; c++) begin
      tick(1);
      if (upd === 1'b1) pulses++;
      if (digits[11:8] === 4'h3) saw3++;
    end
    total++; if (pulses !== 1) begin bad++; $display("FAIL glitch_pulses got=%0d exp=1", pulses); end
    total++; if (saw3 !== 0) begin bad++; $display("FAIL glitch_value3 got=%0d exp=0", saw3); end
    total++; if (digits[11:8] !== 4'h2) begin bad++; $display("FAIL glitch_digit got=%h exp=2", digits[11:8]); end
    total++; if (digit_valid !== 4'b0101) begin bad++; $display("FAIL glitch_valid got=%b exp=0101", digit_valid); end
  endtask

  task automatic test_error_recovery();
    an = 4'b1101; seg = 7'h7E;
    tick(5);
    total++; if (upd !== 1'b1) begin bad++; $display("FAIL err_upd got=%b exp=1", upd); end
    total++; if (upd_idx !== 2'd1) begin bad++; $display("FAIL err_upd_idx got=%0d exp=1", upd_idx); end
    total++; if (digit_err !== 4'b0010) begin bad++; $display("FAIL err_flag got=%b exp=0010", digit_err); end
    total++; if (digit_valid !== 4'b0101) begin bad++; $display("FAIL err_valid got=%b exp=0101", digit_valid); end
    total++; if (digits !== 16'h0205) begin bad++; $display("FAIL err_digits got=%h exp=0205", digits); end
    seg = 7'h30;
    tick(5);
    total++; if (digits[7:4] !== 4'h3) begin bad++; $display("FAIL recover_digit got=%h exp=3", digits[7:4]); end
    total++; if (digit_err !== 4'b0000) begin bad++; $display("FAIL recover_err got=%b exp=0000", digit_err); end
    total++; if (digit_valid !== 4'b0111) begin bad++; $display("FAIL recover_valid got=%b exp=0111", digit_valid); end
  endtask

  task automatic test_anode_faults();
    logic [3:0] bad_an [2] = '{4'b1100, 4'b1111};
    for (int j = 0; j < 2; j++) begin
      int pulses = 0;
      an = bad_an[j]; seg = 7'h00;
      for (int c = 0; c < 10; c++) begin
        tick(1);
        if (upd === 1'b1) pulses++;
      end
      total++; if (pulses !== 0) begin bad++; $display("FAIL anode_upd an=%b got=%0d exp=0", bad_an[j], pulses); end
      total++; if (digits !== 16'h0235) begin bad++; $display("FAIL anode_digits an=%b got=%h exp=0235", bad_an[j], digits); end
      total++; if (digit_valid !== 4'b0111) begin bad++; $display("FAIL anode_valid an=%b got=%b exp=0111", bad_an[j], digit_valid); end
    end
  endtask

  task automatic test_sweep();
    logic [6:0] pats [17] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                              7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E, 7'h7F};
    logic [3:0] exp_nib;
    logic [3:0] exp_blank;
    an = 4'b0111;
    for (int i = 0; i < 17; i++) begin
      seg       = pats[i];
      exp_nib   = (i < 16) ? 4'(i) : 4'h0;
      exp_blank = (i == 16) ? 4'b1000 : 4'b0000;
      tick(5);
      total++; if (upd !== 1'b1 || upd_idx !== 2'd3) begin bad++; $display("FAIL sweep_upd seg=%h got=%b/%0d exp=1/3", pats[i], upd, upd_idx); end
      total++; if (digits[15:12] !== exp_nib) begin bad++; $display("FAIL sweep_digit seg=%h got=%h exp=%h", pats[i], digits[15:12], exp_nib); end
      total++; if (digit_blank !== exp_blank) begin bad++; $display("FAIL sweep_blank seg=%h got=%b exp=%b", pats[i], digit_blank, exp_blank); end
    end
    total++; if (digit_valid !== 4'b1111) begin bad++; $display("FAIL sweep_valid got=%b exp=1111", digit_valid); end
  endtask

  task automatic test_back_to_back();
    an = 4'b1111;
    tick(1);
    an = 4'b0111;
    tick(4);
    total++; if (upd !== 1'b0) begin bad++; $display("FAIL repeat_early_upd got=%b exp=0", upd); end
    tick(1);
    total++; if (upd !== 1'b1 || upd_idx !== 2'd3) begin bad++; $display("FAIL repeat_upd got=%b/%0d exp=1/3", upd, upd_idx); end
    total++; if (digit_blank !== 4'b1000 || digits[15:12] !== 4'h0) begin bad++; $display("FAIL repeat_state got=%b/%h exp=1000/0", digit_blank, digits[15:12]); end
    tick(1);
    total++; if (upd !== 1'b0) begin bad++; $display("FAIL repeat_pulse_width got=%b exp=0", upd); end
  endtask

  task automatic test_reset_mid();
    an = 4'b1110; seg = 7'h79;
    tick(3);
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    total++; if (digits !== 16'h0000 || digit_valid !== 4'b0000 || digit_blank !== 4'b0000 || upd !== 1'b0)
      begin bad++; $display("FAIL midreset_state got=%h/%b/%b/%b exp=0000/0000/0000/0", digits, digit_valid, digit_blank, upd); end
    tick(4);
    total++; if (upd !== 1'b0) begin bad++; $display("FAIL midreset_early_upd got=%b exp=0", upd); end
    tick(1);
    total++; if (upd !== 1'b1 || digits[3:0] !== 4'h1 || digit_valid !== 4'b0001)
      begin bad++; $display("FAIL midreset_commit got=%b/%h/%b exp=1/1/0001", upd, digits[3:0], digit_valid); end
  endtask

  task automatic test_timeout();
    an = 4'b1111; seg = 7'h7F;
`ifdef SEG_STALE_TIMEOUT_EN
    tick(49);
    total++; if (digit_valid[0] !== 1'b1) begin bad++; $display("FAIL timeout_early got=%b exp=1", digit_valid[0]); end
    tick(1);
    total++; if (digit_valid[0] !== 1'b0) begin bad++; $display("FAIL timeout_drop got=%b exp=0", digit_valid[0]); end
    total++; if (digits[3:0] !== 4'h1 || upd !== 1'b0) begin bad++; $display("FAIL timeout_retain got=%h/%b exp=1/0", digits[3:0], upd); end
`else
    tick(60);
    total++; if (digit_valid[0] !== 1'b1) begin bad++; $display("FAIL no_timeout_valid got=%b exp=1", digit_valid[0]); end
    total++; if (digits[3:0] !== 4'h1) begin bad++; $display("FAIL no_timeout_digit got=%h exp=1", digits[3:0]); end
`endif
  endtask

  initial begin
    rst = 1'b1; an = 4'b1111; seg = 7'h7F;
    tick(1);
    test_reset();
    test_basic_decode();
    test_glitch_reject();
    test_error_recovery();
    test_anode_faults();
    test_sweep();
    test_back_to_back();
    test_reset_mid();
    test_timeout();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
